instr_mem_loader: RTL

- Encoder/writer counterpart of the opcode decoder in the ID stage.
- Accepts symbolic instructions (operation select plus register/immediate fields) over a valid/ready handshake.
- Packs each one into the 32-bit instruction word the decoder consumes, then writes it into the byte-addressed instruction memory.
- Writes one byte per cycle, little-endian, at an auto-incrementing address.
- Used by the boot/test loader to fill program memory before the pipeline is released.

---
 rtl/instr_pkg.sv | 76 +++++++
 rtl/instr_mem_loader_if.sv | 30 +++
 rtl/instr_field_packer.sv | 70 +++++++
 rtl/instr_mem_loader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared opcode, op_sel and field-position constants for the instruction encoder/decoder
// Purpose: single source of truth for the 32-bit instruction format. The ID-stage
//          decoder and the memory loader both import this package.
// Ports:   none (package).
package instr_pkg;

  // 6-bit opcodes as seen in word[31:26]
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  // Symbolic operation selects presented by the loader's requester
  localparam logic [4:0] SEL_ADD  = 5'd0;
  localparam logic [4:0] SEL_SUB  = 5'd1;
  localparam logic [4:0] SEL_AND  = 5'd2;
  localparam logic [4:0] SEL_OR   = 5'd3;
  localparam logic [4:0] SEL_NOR  = 5'd4;
  localparam logic [4:0] SEL_XOR  = 5'd5;
  localparam logic [4:0] SEL_SLA  = 5'd6;
  localparam logic [4:0] SEL_SLL  = 5'd7;
  localparam logic [4:0] SEL_SRA  = 5'd8;
  localparam logic [4:0] SEL_SRL  = 5'd9;
  localparam logic [4:0] SEL_ADDI = 5'd10;
  localparam logic [4:0] SEL_SUBI = 5'd11;
  localparam logic [4:0] SEL_LD   = 5'd12;
  localparam logic [4:0] SEL_ST   = 5'd13;
  localparam logic [4:0] SEL_BEZ  = 5'd14;
  localparam logic [4:0] SEL_BNE  = 5'd15;
  localparam logic [4:0] SEL_JMP  = 5'd16;
  localparam logic [4:0] SEL_NOP  = 5'd17;

  // Field bit positions inside the 32-bit word
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int DEST_MSB = 25;
  localparam int DEST_LSB = 21;
  localparam int SRC1_MSB = 20;
  localparam int SRC1_LSB = 16;
  localparam int SRC2_MSB = 15;
  localparam int SRC2_LSB = 11;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_J
  } instr_fmt_t;

  typedef enum logic {
    ST_IDLE,
    ST_WR
  } load_state_t;

  // Little-endian byte lane select: idx 0 is word[7:0]
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - request handshake and byte-write bus of the instruction memory loader
// Purpose: bundles the symbolic-instruction request channel and the byte write
//          port to instruction memory.
// Ports:   master - requester side: drives in_valid/op_sel/dest/src1/src2/imm,
//                   observes in_ready and the memory write strobe/address/data.
//          slave  - loader side: the reverse directions.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        op_sel;
  logic [4:0]        dest;
  logic [4:0]        src1;
  logic [4:0]        src2;
  logic [15:0]       imm;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, op_sel, dest, src1, src2, imm,
    input  in_ready, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, op_sel, dest, src1, src2, imm,
    output in_ready, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational packer from symbolic instruction fields to a 32-bit word
// Purpose: maps op_sel to its opcode and instruction format, then assembles the word.
// Ports:   op_sel, dest, src1, src2 (5 b) and imm (16 b) in;
//          word (32 b) out; legal out, low for op_sel 18-31 (word is then 0).
module instr_field_packer
  import instr_pkg::*;
(
  input  logic [4:0]  op_sel,
  input  logic [4:0]  dest,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic [5:0] opcode;
  instr_fmt_t fmt;

  always_comb begin
    opcode = OP_NOP;
    fmt    = FMT_NONE;
    legal  = 1'b1;
    case (op_sel)
      SEL_ADD:  begin opcode = OP_ADD;  fmt = FMT_R; end
      SEL_SUB:  begin opcode = OP_SUB;  fmt = FMT_R; end
      SEL_AND:  begin opcode = OP_AND;  fmt = FMT_R; end
      SEL_OR:   begin opcode = OP_OR;   fmt = FMT_R; end
      SEL_NOR:  begin opcode = OP_NOR;  fmt = FMT_R; end
      SEL_XOR:  begin opcode = OP_XOR;  fmt = FMT_R; end
      SEL_SLA:  begin opcode = OP_SLA;  fmt = FMT_R; end
      SEL_SLL:  begin opcode = OP_SLL;  fmt = FMT_R; end
      SEL_SRA:  begin opcode = OP_SRA;  fmt = FMT_R; end
      SEL_SRL:  begin opcode = OP_SRL;  fmt = FMT_R; end
      SEL_ADDI: begin opcode = OP_ADDI; fmt = FMT_I; end
      SEL_SUBI: begin opcode = OP_SUBI; fmt = FMT_I; end
      SEL_LD:   begin opcode = OP_LD;   fmt = FMT_I; end
      SEL_ST:   begin opcode = OP_ST;   fmt = FMT_I; end
      SEL_BEZ:  begin opcode = OP_BEZ;  fmt = FMT_I; end
      SEL_BNE:  begin opcode = OP_BNE;  fmt = FMT_I; end
      SEL_JMP:  begin opcode = OP_JMP;  fmt = FMT_J; end
      SEL_NOP:  begin opcode = OP_NOP;  fmt = FMT_NONE; end
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R: begin
        word[OPC_MSB:OPC_LSB]   = opcode;
        word[DEST_MSB:DEST_LSB] = dest;
        word[SRC1_MSB:SRC1_LSB] = src1;
        word[SRC2_MSB:SRC2_LSB] = src2;
      end
      FMT_I: begin
        word[OPC_MSB:OPC_LSB]   = opcode;
        word[DEST_MSB:DEST_LSB] = dest;
        word[SRC1_MSB:SRC1_LSB] = src1;
        word[IMM_MSB:IMM_LSB]   = imm;
      end
      FMT_J: begin
        word[OPC_MSB:OPC_LSB] = opcode;
        word[IMM_MSB:IMM_LSB] = imm;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - packs symbolic instructions and writes them byte-wise into instruction memory
// Purpose: accepts one instruction per handshake, encodes it, and writes its four
//          bytes little-endian over four cycles at an auto-incrementing address.
// Ports:   clk, rst (async, active high), load_start (session restart pulse);
//          bus (slave modport): in_valid/in_ready request handshake with
//          op_sel/dest/src1/src2/imm, and mem_wr_en/mem_addr/mem_wdata byte writes;
//          instr_count, full, err_illegal (sticky), busy status outputs.
module instr_mem_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256,
  parameter int CNT_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  instr_mem_loader_if.slave    bus,
  output logic [CNT_W-1:0]     instr_count,
  output logic                 full,
  output logic                 err_illegal,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  load_state_t       state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [7:0]        wdata_q, wdata_d;

  logic [31:0]       packed_word;
  logic              packed_legal;
  logic              ready;
  logic              accept;
  logic [7:0]        cur_byte;

  instr_field_packer u_packer (
    .op_sel (bus.op_sel),
    .dest   (bus.dest),
    .src1   (bus.src1),
    .src2   (bus.src2),
    .imm    (bus.imm),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  assign full     = (count_q == DEPTH_C);
  // load_start suppresses ready so a restart can never race a new accept
  assign ready    = (state_q == ST_IDLE) && !full && !load_start && !rst;
  assign accept   = ready && bus.in_valid;
  assign cur_byte = word_byte(word_q, idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      word_q  <= '0;
      addr_q  <= BASE;
      count_q <= '0;
      err_q   <= 1'b0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          addr_d  = BASE;
          count_d = '0;
          err_d   = 1'b0;
        end else if (accept) begin
          if (packed_legal) begin
            word_d  = packed_word;
            idx_d   = 2'd0;
            state_d = ST_WR;
          end else begin
            // illegal request is consumed but never reaches memory
            err_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        // load_start is deliberately ignored here; the word always completes
        wdata_d = cur_byte;
        addr_d  = addr_q + ADDR_W'(1);
        if (idx_q == 2'd3) begin
          state_d = ST_IDLE;
          count_d = count_q + CNT_W'(1);
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy          = (state_q == ST_WR);
  assign bus.in_ready  = ready;
  assign bus.mem_wr_en = busy;
  assign bus.mem_addr  = addr_q;
  // outside a write the data bus holds the last byte written
  assign bus.mem_wdata = busy ? cur_byte : wdata_q;
  assign instr_count   = count_q;
  assign err_illegal   = err_q;

endmodule
